// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller:
// FSM state encoding, frame geometry and active-high g..a glyphs for 0-F.
package seg_pkg;

   localparam int FRAME_W = 12;
   localparam int DIGITS  = 4;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SEND  = 2'd1,
      DWELL = 2'd2
   } scan_state_t;

   // Glyphs are active-high, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] GLYPH_0 = 7'h3F;
   localparam logic [6:0] GLYPH_1 = 7'h06;
   localparam logic [6:0] GLYPH_2 = 7'h5B;
   localparam logic [6:0] GLYPH_3 = 7'h4F;
   localparam logic [6:0] GLYPH_4 = 7'h66;
   localparam logic [6:0] GLYPH_5 = 7'h6D;
   localparam logic [6:0] GLYPH_6 = 7'h7D;
   localparam logic [6:0] GLYPH_7 = 7'h07;
   localparam logic [6:0] GLYPH_8 = 7'h7F;
   localparam logic [6:0] GLYPH_9 = 7'h6F;
   localparam logic [6:0] GLYPH_A = 7'h77;
   localparam logic [6:0] GLYPH_B = 7'h7C;
   localparam logic [6:0] GLYPH_C = 7'h39;
   localparam logic [6:0] GLYPH_D = 7'h5E;
   localparam logic [6:0] GLYPH_E = 7'h79;
   localparam logic [6:0] GLYPH_F = 7'h71;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-high 7-segment glyph decoder.
// Polarity and decimal point are applied by the caller.
module hex_to_seg7
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);

   // Plain lookup of the glyph table
   always_comb begin
      glyph = GLYPH_0;
      case (nibble)
         4'h0: glyph = GLYPH_0;
         4'h1: glyph = GLYPH_1;
         4'h2: glyph = GLYPH_2;
         4'h3: glyph = GLYPH_3;
         4'h4: glyph = GLYPH_4;
         4'h5: glyph = GLYPH_5;
         4'h6: glyph = GLYPH_6;
         4'h7: glyph = GLYPH_7;
         4'h8: glyph = GLYPH_8;
         4'h9: glyph = GLYPH_9;
         4'hA: glyph = GLYPH_A;
         4'hB: glyph = GLYPH_B;
         4'hC: glyph = GLYPH_C;
         4'hD: glyph = GLYPH_D;
         4'hE: glyph = GLYPH_E;
         default: glyph = GLYPH_F;
      endcase
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit 7-segment scan scheduler. Offers one {segments, anodes} frame per
// digit over valid/ready, then dwells DWELL_CYCLES before the next digit.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DWELL_CYCLES   = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b0
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_we,
   input  logic [15:0]        i_value,
   input  logic [3:0]         i_dp,
   output logic [FRAME_W-1:0] o_frame,
   output logic               o_frame_valid,
   input  logic               i_frame_ready,
   output logic               o_scan_start
);

   localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [FRAME_W-1:0] BLANK_FRAME =
      {(SEG_ACTIVE_LOW ? 8'hFF : 8'h00), (AN_ACTIVE_LOW ? 4'hF : 4'h0)};

   scan_state_t        state_reg, state_next;
   logic [1:0]         idx_reg, idx_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [15:0]        shadow_value_reg;
   logic [3:0]         shadow_dp_reg;
   logic [15:0]        active_value_reg, active_value_next;
   logic [3:0]         active_dp_reg, active_dp_next;
   logic [FRAME_W-1:0] frame_reg, frame_next;
   logic               scan_start_reg, scan_start_next;

   logic [15:0]        load_value;
   logic [3:0]         load_dp;
   logic [3:0]         cur_nibble;
   logic [6:0]         glyph;
   logic [3:0]         lead_zero;
   logic [3:0]         an_sel;
   logic [7:0]         seg_raw;
   logic [FRAME_W-1:0] built_frame;

   // At digit 0 the scan picks up the newest shadow, including a same-cycle write
   assign load_value = (idx_reg == 2'd0) ? (i_we ? i_value : shadow_value_reg) : active_value_reg;
   assign load_dp    = (idx_reg == 2'd0) ? (i_we ? i_dp : shadow_dp_reg) : active_dp_reg;
   assign cur_nibble = load_value[{idx_reg, 2'b00} +: 4];

   hex_to_seg7 u_dec (
      .nibble (cur_nibble),
      .glyph  (glyph)
   );

   // One-hot anode select, one bit per digit position
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_an
         assign an_sel[gi] = (idx_reg == 2'(gi));
      end
   endgenerate

`ifdef LEADING_ZERO_BLANK_EN
   // A digit is a leading zero when it and every digit to its left are zero
   assign lead_zero[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lz
         assign lead_zero[gi] = (load_value[15:4*gi] == '0);
      end
   endgenerate
`else
   assign lead_zero = 4'b0000;
`endif

   // Assemble the frame for the current digit, then apply output polarities
   always_comb begin
      seg_raw     = {load_dp[idx_reg], (lead_zero[idx_reg] ? 7'h00 : glyph)};
      built_frame = {(SEG_ACTIVE_LOW ? ~seg_raw : seg_raw),
                     (AN_ACTIVE_LOW ? ~an_sel : an_sel)};
   end

   // Next-state logic for the LOAD -> SEND -> DWELL scan loop
   always_comb begin
      state_next        = state_reg;
      idx_next          = idx_reg;
      cnt_next          = cnt_reg;
      active_value_next = active_value_reg;
      active_dp_next    = active_dp_reg;
      frame_next        = frame_reg;
      scan_start_next   = 1'b0;
      case (state_reg)
         LOAD: begin
            frame_next = built_frame;
            if (idx_reg == 2'd0) begin
               active_value_next = load_value;
               active_dp_next    = load_dp;
            end
            state_next = SEND;
         end
         SEND: begin
            if (i_frame_ready) begin
               state_next      = DWELL;
               cnt_next        = '0;
               scan_start_next = (idx_reg == 2'd0);
            end
         end
         DWELL: begin
            if (cnt_reg == CNT_LAST) begin
               idx_next   = idx_reg + 2'd1;
               state_next = LOAD;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: state_next = LOAD;
      endcase
   end

   // Scan state, counters and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= LOAD;
         idx_reg          <= 2'd0;
         cnt_reg          <= '0;
         active_value_reg <= '0;
         active_dp_reg    <= '0;
         frame_reg        <= BLANK_FRAME;
         scan_start_reg   <= 1'b0;
      end else begin
         state_reg        <= state_next;
         idx_reg          <= idx_next;
         cnt_reg          <= cnt_next;
         active_value_reg <= active_value_next;
         active_dp_reg    <= active_dp_next;
         frame_reg        <= frame_next;
         scan_start_reg   <= scan_start_next;
      end
   end

   // Shadow registers follow every write strobe regardless of scan state
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_value_reg <= '0;
         shadow_dp_reg    <= '0;
      end else if (i_we) begin
         shadow_value_reg <= i_value;
         shadow_dp_reg    <= i_dp;
      end
   end

   assign o_frame       = frame_reg;
   assign o_frame_valid = (state_reg == SEND);
   assign o_scan_start  = scan_start_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl with DWELL_CYCLES=4 and default polarities.
// A transaction-level model predicts every frame offer; directed literals pin it.
module tb_seg_scan_ctrl;

   localparam int DW = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_we = 1'b0;
   logic [15:0] i_value = '0;
   logic [3:0]  i_dp = '0;
   logic        i_frame_ready = 1'b1;
   logic [11:0] o_frame;
   logic        o_frame_valid;
   logic        o_scan_start;

   int errors = 0;
   int checks = 0;

   seg_scan_ctrl #(
      .DWELL_CYCLES   (DW),
      .SEG_ACTIVE_LOW (1'b1),
      .AN_ACTIVE_LOW  (1'b0)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_we          (i_we),
      .i_value       (i_value),
      .i_dp          (i_dp),
      .o_frame       (o_frame),
      .o_frame_valid (o_frame_valid),
      .i_frame_ready (i_frame_ready),
      .o_scan_start  (o_scan_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] glyph_of(input logic [3:0] n);
      logic [6:0] table_g [16];
      table_g = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return table_g[n];
   endfunction

   // Expected frame for digit k of value v: active-low segments, active-high anode
   function automatic logic [11:0] model_frame(input logic [15:0] v, input logic [3:0] dp, input int k);
      logic [15:0] sh;
      logic [6:0]  g;
      logic [3:0]  an;
      sh = v >> (4 * k);
      g  = glyph_of(sh[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 0 && sh == 16'h0) g = 7'h00;
`endif
      an = 4'b0001 << k;
      return {~{dp[k], g}, an};
   endfunction

   // Model: after each accepted frame the next offer appears DW+1 clocks later
   logic        m_init = 1'b0;
   logic        m_valid, m_start;
   logic [11:0] m_frame;
   logic [15:0] m_shadow, m_active;
   logic [3:0]  m_sdp, m_adp;
   int          m_idx, m_wait;

   initial begin
      forever begin
         @(negedge clk);
         if (m_init) begin
            check("frame_valid", {31'b0, o_frame_valid}, {31'b0, m_valid});
            check("scan_start", {31'b0, o_scan_start}, {31'b0, m_start});
            check("frame", {20'b0, o_frame}, {20'b0, m_frame});
            if (o_frame_valid)
               check("anode_onehot", {31'b0, $onehot(o_frame[3:0])}, 32'd1);
         end
         if (rst) begin
            m_valid  = 1'b0;
            m_start  = 1'b0;
            m_frame  = 12'hFF0;
            m_idx    = 0;
            m_wait   = 1;
            m_shadow = '0;
            m_sdp    = '0;
            m_active = '0;
            m_adp    = '0;
            m_init   = 1'b1;
         end else if (m_init) begin
            m_start = m_valid && i_frame_ready && (m_idx == 0);
            if (m_valid) begin
               if (i_frame_ready) begin
                  m_valid = 1'b0;
                  m_wait  = DW + 1;
                  m_idx   = (m_idx + 1) % 4;
               end
            end else begin
               m_wait--;
               if (m_wait == 0) begin
                  if (m_idx == 0) begin
                     m_active = i_we ? i_value : m_shadow;
                     m_adp    = i_we ? i_dp : m_sdp;
                  end
                  m_valid = 1'b1;
                  m_frame = model_frame(m_active, m_adp, m_idx);
               end
            end
            if (i_we) begin
               m_shadow = i_value;
               m_sdp    = i_dp;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Advance until a frame for anode 'an' is offered; n = clocks taken
   task automatic wait_anode(input logic [3:0] an, output int n);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         n++;
         if (o_frame_valid && o_frame[3:0] == an) return;
      end
      checks++;
      errors++;
      $display("FAIL wait_anode_%b: got no offer expected one within 200 cycles", an);
   endtask

   int n;

   initial begin
      repeat (3) step();
      check("reset_valid", {31'b0, o_frame_valid}, 32'd0);
      check("reset_frame", {20'b0, o_frame}, 32'hFF0);

      // Release reset with a write landing on the first LOAD (write-through)
      rst = 1'b0; i_we = 1'b1; i_value = 16'h1234; i_dp = 4'b0000;
      step();
      i_we = 1'b0;
      check("first_valid", {31'b0, o_frame_valid}, 32'd1);
      check("frame_d0_1234", {20'b0, o_frame}, 32'h991);
      wait_anode(4'b0010, n);
      check("valid_period", n, 32'd6);
      check("frame_d1_1234", {20'b0, o_frame}, 32'hB02);
      wait_anode(4'b0100, n);
      check("frame_d2_1234", {20'b0, o_frame}, 32'hA44);
      wait_anode(4'b1000, n);
      check("frame_d3_1234", {20'b0, o_frame}, 32'hF98);

      // Scan start pulses once after the digit-0 transfer
      wait_anode(4'b0001, n);
      step();
      check("scan_start_pulse", {31'b0, o_scan_start}, 32'd1);
      step();
      check("scan_start_clear", {31'b0, o_scan_start}, 32'd0);

      // Backpressure on digit 1
      wait_anode(4'b0010, n);
      i_frame_ready = 1'b0;
      repeat (20) step();
      check("bp_valid_held", {31'b0, o_frame_valid}, 32'd1);
      check("bp_frame_held", {20'b0, o_frame}, 32'hB02);
      i_frame_ready = 1'b1;
      step();
      check("bp_released", {31'b0, o_frame_valid}, 32'd0);

      // Tear-free update while digit 2 dwells
      wait_anode(4'b0100, n);
      step();
      i_we = 1'b1; i_value = 16'hABCD; i_dp = 4'b0000;
      step();
      i_we = 1'b0;
      wait_anode(4'b1000, n);
      check("tear_d3_old", {20'b0, o_frame}, 32'hF98);
      wait_anode(4'b0001, n);
      check("new_d0_D", {20'b0, o_frame}, 32'hA11);
      wait_anode(4'b0010, n);
      check("new_d1_C", {20'b0, o_frame}, 32'hC62);

      // All-zero value with decimal point on digit 1
      i_we = 1'b1; i_value = 16'h0000; i_dp = 4'b0010;
      step();
      i_we = 1'b0;
      wait_anode(4'b0001, n);
      check("zero_d0", {20'b0, o_frame}, 32'hC01);
      wait_anode(4'b0010, n);
`ifdef LEADING_ZERO_BLANK_EN
      check("zero_d1_dp", {20'b0, o_frame}, 32'h7F2);
`else
      check("zero_d1_dp", {20'b0, o_frame}, 32'h402);
`endif
      wait_anode(4'b0100, n);
`ifdef LEADING_ZERO_BLANK_EN
      check("zero_d2", {20'b0, o_frame}, 32'hFF4);
`else
      check("zero_d2", {20'b0, o_frame}, 32'hC04);
`endif

      // Reset during digit 2 dwell
      step();
      step();
      rst = 1'b1;
      step();
      check("rst_valid", {31'b0, o_frame_valid}, 32'd0);
      check("rst_start", {31'b0, o_scan_start}, 32'd0);
      check("rst_frame", {20'b0, o_frame}, 32'hFF0);
      step();
      rst = 1'b0;
      wait_anode(4'b0001, n);
      check("post_rst_d0", {20'b0, o_frame}, 32'hC01);

      // A further full rotation to exercise the index wrap
      wait_anode(4'b0010, n);
      wait_anode(4'b0100, n);
      wait_anode(4'b1000, n);
      wait_anode(4'b0001, n);
      check("wrap_d0", {20'b0, o_frame}, 32'hC01);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
